// File: rtl/fc_quant_pkg.sv
// fc_quant_pkg
//   Shared widths and types for the FC accumulate/requantize datapath, plus
//   requant_ref(), a plain-arithmetic requantization reference used by the
//   scoreboard to score the hardware against the golden software flow.
package fc_quant_pkg;

    localparam int ACC_W  = 32;
    localparam int PROD_W = 32;
    localparam int MUL_W  = 64;
    localparam int DATA_W = 8;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [MUL_W-1:0]  mul_t;
    typedef logic signed [DATA_W-1:0] q8_t;

    // dot: wrapped 32-bit dot product of the neuron. Returns the int8 output.
    function automatic q8_t requant_ref(input acc_t dot, input acc_t bias,
                                        input logic relu_en, input acc_t quant_mult,
                                        input acc_t quant_shift, input q8_t out_zp,
                                        input logic saturate);
        acc_t              sum;
        mul_t              prod;
        mul_t              scaled;
        int                total_shift;
        logic signed [15:0] o16;
        q8_t               res;
        sum = dot + bias;
        if (relu_en && sum < 0) sum = '0;
        prod        = mul_t'(sum) * mul_t'(quant_mult);
        total_shift = 31 - int'(quant_shift);
        scaled      = (prod + (mul_t'(1) <<< (total_shift - 1))) >>> total_shift;
        o16         = scaled[15:0] + 16'(out_zp);
        res         = q8_t'(o16[7:0]);
        if (saturate) begin
            if (o16 > 16'sd127)       res = 8'sh7f;
            else if (o16 < -16'sd128) res = -8'sd128;
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_requantizer.sv
// fc_requantizer
//   Three-stage requantization pipe behind the accumulator. Every register
//   advances only when i_en (the global advance) is high.
//     S1: sum = acc + bias, optional ReLU
//     S2: 64-bit product with quant_mult
//     S3: round, arithmetic shift, add zero-point, truncate or clamp to int8
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en                  pipe advance
//   i_valid, i_acc, i_bias, i_relu_en, i_idx   finished neuron entering S1
//   i_quant_mult, i_quant_shift, i_out_zp      layer-static requant params
//   o_valid, o_data, o_idx                     output register
module fc_requantizer
    import fc_quant_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  acc_t             i_acc,
    input  acc_t             i_bias,
    input  logic             i_relu_en,
    input  logic [IDX_W-1:0] i_idx,
    input  acc_t             i_quant_mult,
    input  acc_t             i_quant_shift,
    input  q8_t              i_out_zp,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic [IDX_W-1:0] o_idx
);

    logic             s1_v, s2_v, s3_v;
    acc_t             s1_acc, s1_bias;
    logic             s1_relu;
    logic [IDX_W-1:0] s1_idx, s2_idx, s3_idx;
    acc_t             s2_r;
    mul_t             s3_p;

    acc_t               sum;
    acc_t               relu_sum;
    mul_t               product;
    acc_t               total_shift;
    logic [5:0]         shift_amt;
    mul_t               round_inc;
    mul_t               p_round;
    logic signed [15:0] o16;
    logic [7:0]         q_sat;
    logic [7:0]         q_out;

    assign sum      = s1_acc + s1_bias;
    assign relu_sum = (s1_relu && sum[31]) ? '0 : sum;
    assign product  = mul_t'(s2_r) * mul_t'(i_quant_mult);

    // Legal total shift is 1..62, so the low 6 bits carry the whole amount.
    assign total_shift = 32'sd31 - i_quant_shift;
    assign shift_amt   = total_shift[5:0];
    assign round_inc   = mul_t'(1) << (shift_amt - 6'd1);
    assign p_round     = s3_p + round_inc;
    assign o16         = 16'(p_round >>> shift_amt) + {{8{i_out_zp[7]}}, i_out_zp};

    always_comb begin
        q_sat = o16[7:0];
        if (o16 > 16'sd127)       q_sat = 8'h7f;
        else if (o16 < -16'sd128) q_sat = 8'h80;
    end

    assign q_out = SATURATE ? q_sat : o16[7:0];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_valid) begin
                s1_acc  <= i_acc;
                s1_bias <= i_bias;
                s1_relu <= i_relu_en;
                s1_idx  <= i_idx;
            end
            if (s1_v) begin
                s2_r   <= relu_sum;
                s2_idx <= s1_idx;
            end
            if (s2_v) begin
                s3_p   <= product;
                s3_idx <= s2_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
        end else if (i_en) begin
            s1_v    <= i_valid;
            s2_v    <= s1_v;
            s3_v    <= s2_v;
            o_valid <= s3_v;
            if (s3_v) begin
                o_data <= q_out;
                o_idx  <= s3_idx;
            end
        end
    end

    a_shift_legal : assert property (@(posedge i_clk) disable iff (i_rst)
        s3_v |-> (total_shift >= 32'sd1 && total_shift <= 32'sd62));

endmodule

// File: rtl/fc_requant_stage.sv
// fc_requant_stage
//   Accumulates the signed product stream of one neuron, then hands the dot
//   product with its bias/ReLU setting to the requantizer pipe. One int8
//   result per neuron, tagged with its index within the layer.
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_layer_start                 clear neuron index, restart accumulation
//   i_valid, o_ready, i_product, i_last, i_bias, i_relu_en   product beats
//   i_quant_mult, i_quant_shift, i_out_zp                    layer params
//   o_valid, i_ready, o_data, o_idx                          results
module fc_requant_stage
    import fc_quant_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_layer_start,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [31:0] i_product,
    input  logic               i_last,
    input  logic signed [31:0] i_bias,
    input  logic               i_relu_en,
    input  logic signed [31:0] i_quant_mult,
    input  logic signed [31:0] i_quant_shift,
    input  logic signed [7:0]  i_out_zp,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [7:0]         o_data,
    output logic [IDX_W-1:0]   o_idx
);

    logic             adv;
    logic             hs;
    logic             first_q;
    acc_t             acc_q;
    acc_t             acc_next;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_base;
    logic             done_valid;

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;
    assign hs      = i_valid && adv;

    // A layer start on the same cycle as a beat makes that beat the first term.
    assign acc_next   = (first_q || i_layer_start) ? i_product : acc_q + i_product;
    assign idx_base   = i_layer_start ? '0 : idx_q;
    assign done_valid = hs && i_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            idx_q   <= '0;
        end else begin
            if (hs) begin
                acc_q   <= acc_next;
                first_q <= i_last;
            end else if (i_layer_start) begin
                first_q <= 1'b1;
            end
            idx_q <= done_valid ? idx_base + IDX_W'(1) : idx_base;
        end
    end

    // The index travels with the neuron, so results already in the pipe keep
    // theirs across a layer start.
    fc_requantizer #(
        .IDX_W   (IDX_W),
        .SATURATE(SATURATE)
    ) u_requantizer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (adv),
        .i_valid      (done_valid),
        .i_acc        (acc_next),
        .i_bias       (i_bias),
        .i_relu_en    (i_relu_en),
        .i_idx        (idx_base),
        .i_quant_mult (i_quant_mult),
        .i_quant_shift(i_quant_shift),
        .i_out_zp     (i_out_zp),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_idx        (o_idx)
    );

endmodule

// File: tb/tb_fc_requant_stage.sv
module tb_fc_requant_stage;
    import fc_quant_pkg::*;

    localparam int IDX_W = 8;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_layer_start;
    logic               i_valid;
    logic               i_last;
    logic               i_relu_en;
    logic               i_ready;
    logic signed [31:0] i_product;
    logic signed [31:0] i_bias;
    logic signed [31:0] i_quant_mult;
    logic signed [31:0] i_quant_shift;
    logic signed [7:0]  i_out_zp;

    logic               o_ready, o_valid;
    logic [7:0]         o_data;
    logic [IDX_W-1:0]   o_idx;
    logic               o_ready_s, o_valid_s;
    logic [7:0]         o_data_s;
    logic [IDX_W-1:0]   o_idx_s;

    always #5 i_clk = ~i_clk;

    fc_requant_stage #(.IDX_W(IDX_W), .SATURATE(1'b0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_layer_start(i_layer_start),
        .i_valid(i_valid), .o_ready(o_ready), .i_product(i_product),
        .i_last(i_last), .i_bias(i_bias), .i_relu_en(i_relu_en),
        .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
        .i_out_zp(i_out_zp), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_idx(o_idx)
    );

    fc_requant_stage #(.IDX_W(IDX_W), .SATURATE(1'b1)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_layer_start(i_layer_start),
        .i_valid(i_valid), .o_ready(o_ready_s), .i_product(i_product),
        .i_last(i_last), .i_bias(i_bias), .i_relu_en(i_relu_en),
        .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
        .i_out_zp(i_out_zp), .o_valid(o_valid_s), .i_ready(i_ready),
        .o_data(o_data_s), .o_idx(o_idx_s)
    );

    typedef struct {
        logic [7:0]       d;
        logic [7:0]       ds;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t             q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    int               hs_cyc   = 0;
    bit               rand_ready = 0;

    // Reference state: running dot product, first-term flag, next index.
    int               m_acc   = 0;
    bit               m_first = 1;
    logic [IDX_W-1:0] m_idx   = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic send_beat(input int prod, input bit last, input int bias,
                             input bit relu, input bit ls);
        int   n;
        exp_t e;
        n = 0;
        i_valid = 1'b1; i_product = prod; i_last = last;
        i_bias = bias; i_relu_en = relu; i_layer_start = ls;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            if (ls) begin m_first = 1; m_idx = '0; end
            n++;
            if (n > 500) begin chk("beat_accept_timeout", o_ready, 1); break; end
        end
        if (ls) m_idx = '0;
        if (m_first || ls) m_acc = prod;
        else               m_acc = m_acc + prod;
        if (last) begin
            e.d   = requant_ref(m_acc, bias, relu, i_quant_mult, i_quant_shift, i_out_zp, 1'b0);
            e.ds  = requant_ref(m_acc, bias, relu, i_quant_mult, i_quant_shift, i_out_zp, 1'b1);
            e.idx = m_idx;
            q.push_back(e);
            m_idx   = m_idx + 1'b1;
            m_first = 1;
        end else begin
            m_first = 0;
        end
        hs_cyc = cyc;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_layer_start = 1'b0;
    endtask

    task automatic pulse_ls();
        i_layer_start = 1'b1; i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_layer_start = 1'b0;
        m_first = 1; m_idx = '0;
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1; i_valid = 1'b0; i_layer_start = 1'b0;
        repeat (n) begin @(posedge i_clk); #1; end
        i_rst = 1'b0;
        m_first = 1; m_idx = '0; m_acc = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin @(posedge i_clk); #1; n++; end
        chk("drain_empty", q.size(), 0);
    endtask

    // Called right after a last-beat handshake with i_ready held high.
    task automatic wait_result(input string tag, input logic [7:0] exp_d,
                               input logic [7:0] exp_ds, input logic [IDX_W-1:0] exp_idx);
        int lat;
        lat = 0;
        while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, o_data, exp_d);
        chk({tag, "_data_sat"}, o_data_s, exp_ds);
        chk({tag, "_idx"}, o_idx, exp_idx);
    endtask

    // Ready randomizer.
    initial begin
        forever begin
            @(posedge i_clk); #1;
            if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: every cycle the head result must be presented
    // unchanged until it is accepted.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                q.delete();
            end else if (q.size() == 0) begin
                chk("no_spurious_valid", {o_valid, o_valid_s}, 0);
            end else if (o_valid) begin
                chk("out_data", o_data, q[0].d);
                chk("out_data_sat", o_data_s, q[0].ds);
                chk("out_idx", o_idx, q[0].idx);
                if (i_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [15:0] a16, b16;
        int                 first_hs, bias_r;
        bit                 relu_r;

        i_rst = 1'b1; i_layer_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_relu_en = 1'b0; i_ready = 1'b1; i_product = '0; i_bias = '0;
        i_quant_mult = 32'h4000_0000; i_quant_shift = 0; i_out_zp = -8'sd128;
        do_reset(3);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_idx", o_idx, 0);
        chk("rst_o_ready", o_ready, 1);

        // Multi-beat neuron with bias and ReLU enabled.
        send_beat(100, 0, 10, 1, 0);
        send_beat(200, 0, 10, 1, 0);
        send_beat(-50, 1, 10, 1, 0);
        wait_result("t1", 8'h02, 8'h02, 0);

        // Negative sum with and without ReLU.
        send_beat(-200, 1, 0, 1, 0);
        wait_result("t2_relu", 8'h80, 8'h80, 1);
        send_beat(-200, 1, 0, 0, 0);
        wait_result("t2_norelu", 8'h1C, 8'h80, 2);

        // Overflow of int8: wrap vs clamp.
        i_quant_shift = 1; i_out_zp = 0;
        send_beat(300, 1, 0, 0, 0);
        wait_result("t3", 8'h2C, 8'h7F, 3);
        drain();

        // Back-to-back single-beat neurons, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            send_beat($urandom_range(0, 4000) - 2000, 1, 0, 0, i == 0);
            if (i == 0) first_hs = hs_cyc;
        end
        chk("b2b_span", hs_cyc - first_hs, 9);
        drain();

        // Same with a randomly stalling consumer.
        rand_ready = 1;
        for (int i = 0; i < 10; i++)
            send_beat($urandom_range(0, 4000) - 2000, 1, $urandom_range(0, 20) - 10, i[0], i == 0);
        drain();
        rand_ready = 0; i_ready = 1'b1;

        // Layer start: partial neuron discarded, beat with layer start is first,
        // in-flight results keep their index.
        pulse_ls();
        send_beat(1000, 0, 0, 0, 0);
        send_beat(2000, 0, 0, 0, 0);
        send_beat(7, 0, 0, 0, 1);
        send_beat(5, 1, 3, 0, 0);
        send_beat(40, 1, 0, 0, 0);
        pulse_ls();
        send_beat(60, 1, 0, 0, 0);
        drain();

        // Reset mid-neuron.
        send_beat(11, 0, 0, 0, 0);
        send_beat(22, 0, 0, 0, 0);
        do_reset(1);
        chk("rst_mid_o_valid", o_valid, 0);
        chk("rst_mid_o_idx", o_idx, 0);
        send_beat(33, 1, 5, 0, 0);
        wait_result("t5_after_rst", 8'h26, 8'h26, 0);
        drain();

        // Reset with two results in flight.
        send_beat(70, 1, 0, 0, 0);
        send_beat(80, 1, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            chk("rst_flush_valid", o_valid, 0);
            @(posedge i_clk); #1;
        end
        send_beat(-9, 1, 0, 0, 0);
        drain();

        // Index wrap over a long layer of single-beat neurons.
        rand_ready = 1;
        i_quant_mult = $urandom; i_quant_shift = $urandom_range(0, 61) - 31;
        i_out_zp = 8'($urandom);
        pulse_ls();
        for (int i = 0; i < 300; i++)
            send_beat($urandom, 1, $urandom, $urandom_range(0, 1), 0);
        drain();

        // Full 784x32 layer of exact 16x16 products.
        i_quant_mult = $urandom; i_quant_shift = $urandom_range(0, 61) - 31;
        i_out_zp = 8'($urandom);
        pulse_ls();
        for (int n = 0; n < 32; n++) begin
            bias_r = $urandom_range(0, 200000) - 100000;
            relu_r = $urandom_range(0, 1);
            for (int k = 0; k < 784; k++) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                send_beat(int'(a16) * int'(b16), k == 783, bias_r, relu_r, 0);
                if ($urandom_range(0, 7) == 0) begin @(posedge i_clk); #1; end
            end
        end
        drain();
        rand_ready = 0; i_ready = 1'b1;

        repeat (5) @(posedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
